// File: rtl/rv_decode_issue.sv
// RV32I decode/issue stage: decodes one instruction per handshake into a registered ID/EX slot.
// Latency: 1 cycle from accept to out_valid; 1 instruction/cycle sustained without hazards.
// Backpressure: slot holds while out_ready is low; load-use interlock and flush drop in_ready.
// Optional feature macro: ILLEGAL_TRAP_EN (issue illegal words flagged, otherwise as a NOP).
module rv_decode_issue #(
    parameter int LOAD_USE_BUBBLES = 1,
    parameter int PC_W             = 12
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [31:0]     in_insn,
    input  logic [PC_W-1:0] in_pc,
    output logic [4:0]      rs1_addr,
    output logic [4:0]      rs2_addr,
    input  logic [31:0]     rs1_data,
    input  logic [31:0]     rs2_data,
    input  logic            flush,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [4:0]      out_aluop,
    output logic            out_sign,
    output logic [31:0]     out_data1,
    output logic [31:0]     out_op2,
    output logic [31:0]     out_rs2val,
    output logic [PC_W-1:0] out_pc,
    output logic [31:0]     out_imm,
    output logic [4:0]      out_rd,
    output logic            out_regwrite,
    output logic            out_memread,
    output logic            out_memwrite,
    output logic            out_branch,
    output logic            out_illegal
);

    localparam logic [4:0] ALU_ADD  = 5'b00000;
    localparam logic [4:0] ALU_SUB  = 5'b00001;
    localparam logic [4:0] ALU_SLL  = 5'b00010;
    localparam logic [4:0] ALU_XOR  = 5'b00011;
    localparam logic [4:0] ALU_SRL  = 5'b00100;
    localparam logic [4:0] ALU_SRA  = 5'b00101;
    localparam logic [4:0] ALU_OR   = 5'b00110;
    localparam logic [4:0] ALU_AND  = 5'b00111;
    localparam logic [4:0] ALU_SLT  = 5'b01000;
    localparam logic [4:0] ALU_PASS = 5'b01001;

    localparam logic [6:0] OPC_OP     = 7'b0110011;
    localparam logic [6:0] OPC_OPIMM  = 7'b0010011;
    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC  = 7'b0010111;

    // Counter reloads with one less than the bubble count: the cycle the load
    // leaves already counts as the first bubble.
    localparam logic [1:0] BUBBLE_RELOAD = 2'(LOAD_USE_BUBBLES - 1);

    // Instruction fields and immediates
    logic [6:0]  opcode;
    logic [2:0]  funct3;
    logic [4:0]  rd_fld;
    logic [31:0] imm_i, imm_s, imm_b, imm_u;

    assign opcode   = in_insn[6:0];
    assign funct3   = in_insn[14:12];
    assign rd_fld   = in_insn[11:7];
    assign rs1_addr = in_insn[19:15];
    assign rs2_addr = in_insn[24:20];
    assign imm_i    = {{20{in_insn[31]}}, in_insn[31:20]};
    assign imm_s    = {{20{in_insn[31]}}, in_insn[31:25], in_insn[11:7]};
    assign imm_b    = {{19{in_insn[31]}}, in_insn[31], in_insn[7], in_insn[30:25], in_insn[11:8], 1'b0};
    assign imm_u    = {in_insn[31:12], 12'b0};

    // Decoded next-slot contents
    logic [4:0]      aluop_d;
    logic            sign_d;
    logic [31:0]     data1_d, op2_d, rs2val_d, imm_d;
    logic [4:0]      rd_d;
    logic            regwrite_d, memread_d, memwrite_d, branch_d, illegal_d;
    logic            uses_rs1, uses_rs2;

    // Slot state
    logic            valid_q, valid_d;
    logic [1:0]      bubble_q, bubble_d;
    logic [4:0]      load_rd_q, load_rd_d;
    logic [4:0]      aluop_q;
    logic            sign_q;
    logic [31:0]     data1_q, op2_q, rs2val_q, imm_q;
    logic [PC_W-1:0] pc_q;
    logic [4:0]      rd_q;
    logic            regwrite_q, memread_q, memwrite_q, branch_q;

    logic            hazard;
    logic            xfer;

    // Decode the offered instruction into ALU, memory and writeback controls
    always_comb begin
        aluop_d    = ALU_ADD;
        sign_d     = 1'b1;
        data1_d    = rs1_data;
        op2_d      = 32'd0;
        rs2val_d   = 32'd0;
        imm_d      = 32'd0;
        rd_d       = 5'd0;
        regwrite_d = 1'b0;
        memread_d  = 1'b0;
        memwrite_d = 1'b0;
        branch_d   = 1'b0;
        illegal_d  = 1'b0;
        uses_rs1   = 1'b0;
        uses_rs2   = 1'b0;
        case (opcode)
            OPC_OP: begin
                uses_rs1   = 1'b1;
                uses_rs2   = 1'b1;
                op2_d      = rs2_data;
                rd_d       = rd_fld;
                regwrite_d = 1'b1;
                case (funct3)
                    3'b000:  aluop_d = in_insn[30] ? ALU_SUB : ALU_ADD;
                    3'b001:  aluop_d = ALU_SLL;
                    3'b010:  aluop_d = ALU_SLT;
                    3'b011: begin
                        aluop_d = ALU_SLT;
                        sign_d  = 1'b0;
                    end
                    3'b100:  aluop_d = ALU_XOR;
                    3'b101:  aluop_d = in_insn[30] ? ALU_SRA : ALU_SRL;
                    3'b110:  aluop_d = ALU_OR;
                    default: aluop_d = ALU_AND;
                endcase
            end
            OPC_OPIMM: begin
                uses_rs1   = 1'b1;
                op2_d      = imm_i;
                imm_d      = imm_i;
                rd_d       = rd_fld;
                regwrite_d = 1'b1;
                case (funct3)
                    3'b000:  aluop_d = ALU_ADD;
                    3'b001: begin
                        aluop_d = ALU_SLL;
                        op2_d   = {27'b0, in_insn[24:20]};
                    end
                    3'b010:  aluop_d = ALU_SLT;
                    3'b011: begin
                        aluop_d = ALU_SLT;
                        sign_d  = 1'b0;
                    end
                    3'b100:  aluop_d = ALU_XOR;
                    3'b101: begin
                        aluop_d = in_insn[30] ? ALU_SRA : ALU_SRL;
                        op2_d   = {27'b0, in_insn[24:20]};
                    end
                    3'b110:  aluop_d = ALU_OR;
                    default: aluop_d = ALU_AND;
                endcase
            end
            OPC_LOAD: begin
                uses_rs1   = 1'b1;
                op2_d      = imm_i;
                imm_d      = imm_i;
                rd_d       = rd_fld;
                regwrite_d = 1'b1;
                memread_d  = 1'b1;
            end
            OPC_STORE: begin
                uses_rs1   = 1'b1;
                uses_rs2   = 1'b1;
                op2_d      = imm_s;
                imm_d      = imm_s;
                rs2val_d   = rs2_data;
                memwrite_d = 1'b1;
            end
            OPC_BRANCH: begin
                uses_rs1 = 1'b1;
                uses_rs2 = 1'b1;
                op2_d    = rs2_data;
                imm_d    = imm_b;
                branch_d = 1'b1;
                case (funct3)
                    3'b000, 3'b001: aluop_d = ALU_SUB;
                    3'b100, 3'b101: aluop_d = ALU_SLT;
                    3'b110, 3'b111: begin
                        aluop_d = ALU_SLT;
                        sign_d  = 1'b0;
                    end
                    default: illegal_d = 1'b1;
                endcase
            end
            OPC_LUI: begin
                aluop_d    = ALU_PASS;
                data1_d    = 32'd0;
                op2_d      = imm_u;
                imm_d      = imm_u;
                rd_d       = rd_fld;
                regwrite_d = 1'b1;
            end
            OPC_AUIPC: begin
                data1_d    = 32'(in_pc);
                op2_d      = imm_u;
                imm_d      = imm_u;
                rd_d       = rd_fld;
                regwrite_d = 1'b1;
            end
            default: illegal_d = 1'b1;
        endcase
        // Illegal words become an inert add of zeros with every control cleared
        if (illegal_d) begin
            aluop_d    = ALU_ADD;
            sign_d     = 1'b0;
            data1_d    = 32'd0;
            op2_d      = 32'd0;
            rs2val_d   = 32'd0;
            imm_d      = 32'd0;
            rd_d       = 5'd0;
            regwrite_d = 1'b0;
            memread_d  = 1'b0;
            memwrite_d = 1'b0;
            branch_d   = 1'b0;
            uses_rs1   = 1'b0;
            uses_rs2   = 1'b0;
        end
        // x0 is never written
        if (rd_d == 5'd0) begin
            regwrite_d = 1'b0;
        end
    end

    // A load in the slot whose rd is read by the offered instruction must not be bypassed
    assign hazard = valid_q && (load_rd_q != 5'd0) &&
                    ((uses_rs1 && (rs1_addr == load_rd_q)) ||
                     (uses_rs2 && (rs2_addr == load_rd_q)));

    assign in_ready = !reset && !flush && (bubble_q == 2'd0) && !hazard &&
                      (!valid_q || out_ready);
    assign xfer     = in_valid && in_ready;

    // Next state of slot occupancy, bubble counter and pending load destination
    always_comb begin
        valid_d   = valid_q;
        bubble_d  = bubble_q;
        load_rd_d = load_rd_q;
        if (flush) begin
            valid_d   = 1'b0;
            bubble_d  = 2'd0;
            load_rd_d = 5'd0;
        end else begin
            if (bubble_q != 2'd0) begin
                bubble_d = bubble_q - 2'd1;
            end
            if (hazard && out_ready) begin
                bubble_d = BUBBLE_RELOAD;
            end
            if (xfer) begin
                valid_d   = 1'b1;
                load_rd_d = memread_d ? rd_d : 5'd0;
            end else if (out_ready) begin
                valid_d   = 1'b0;
                load_rd_d = 5'd0;
            end
        end
    end

    // Control state registers
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            valid_q   <= 1'b0;
            bubble_q  <= 2'd0;
            load_rd_q <= 5'd0;
        end else begin
            valid_q   <= valid_d;
            bubble_q  <= bubble_d;
            load_rd_q <= load_rd_d;
        end
    end

    // ID/EX payload, captured only on an accepted transfer so it holds under backpressure
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            aluop_q    <= 5'd0;
            sign_q     <= 1'b0;
            data1_q    <= 32'd0;
            op2_q      <= 32'd0;
            rs2val_q   <= 32'd0;
            imm_q      <= 32'd0;
            pc_q       <= '0;
            rd_q       <= 5'd0;
            regwrite_q <= 1'b0;
            memread_q  <= 1'b0;
            memwrite_q <= 1'b0;
            branch_q   <= 1'b0;
        end else if (xfer) begin
            aluop_q    <= aluop_d;
            sign_q     <= sign_d;
            data1_q    <= data1_d;
            op2_q      <= op2_d;
            rs2val_q   <= rs2val_d;
            imm_q      <= imm_d;
            pc_q       <= in_pc;
            rd_q       <= rd_d;
            regwrite_q <= regwrite_d;
            memread_q  <= memread_d;
            memwrite_q <= memwrite_d;
            branch_q   <= branch_d;
        end
    end

`ifdef ILLEGAL_TRAP_EN
    logic illegal_q;

    // Illegal flag travels with the slot so execute can raise the trap
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            illegal_q <= 1'b0;
        end else if (xfer) begin
            illegal_q <= illegal_d;
        end
    end

    assign out_illegal = illegal_q;
`else
    assign out_illegal = 1'b0;
`endif

    assign out_valid    = valid_q;
    assign out_aluop    = aluop_q;
    assign out_sign     = sign_q;
    assign out_data1    = data1_q;
    assign out_op2      = op2_q;
    assign out_rs2val   = rs2val_q;
    assign out_pc       = pc_q;
    assign out_imm      = imm_q;
    assign out_rd       = rd_q;
    assign out_regwrite = regwrite_q;
    assign out_memread  = memread_q;
    assign out_memwrite = memwrite_q;
    assign out_branch   = branch_q;

endmodule

// File: doc/rv_decode_issue.md
Name: rv_decode_issue

Overview:
- Decode/issue stage of the RV32 pipeline; the producer side of the execute-stage ALU interface.
- Decodes one RV32I instruction per handshake and reads register-file data through external read ports.
- Generates the ALU's aluop/sign/data1/op2 fields plus memory and writeback controls.
- Holds everything in a registered ID/EX slot with valid/ready backpressure, load-use interlock and flush.

Parameters:
- LOAD_USE_BUBBLES, 1, bubbles inserted after a load whose rd feeds the next instruction (legal range 1-3).
- PC_W, 12, program-counter width, matching the PC adder.

Ports:
- clk  in  1  clock, rising edge.
- reset  in  1  asynchronous, active-high reset.
- in_valid  in  1  fetch offers instruction.
- in_ready  out  1  stage accepts instruction this cycle.
- in_insn  in  32  instruction word.
- in_pc  in  PC_W  instruction PC.
- rs1_addr, rs2_addr  out  5  regfile read addresses, combinational from in_insn.
- rs1_data, rs2_data  in  32  regfile read data, same cycle.
- flush  in  1  kill slot contents and any pending bubble.
- out_valid  out  1  ID/EX slot holds an instruction.
- out_ready  in  1  execute consumes slot.
- out_aluop  out  5  ALU opcode.
- out_sign  out  1  signed compare/subtract select.
- out_data1  out  32  ALU operand 1.
- out_op2  out  32  ALU operand 2.
- out_rs2val  out  32  store data.
- out_pc  out  PC_W  PC of the instruction.
- out_imm  out  32  sign-extended immediate, for branch target.
- out_rd  out  5  destination register.
- out_regwrite, out_memread, out_memwrite, out_branch  out  1  control flags.
- out_illegal  out  1  illegal-instruction flag.

Behaviour:
- Reset (async): every out_* signal 0, bubble counter 0, load_rd 0. in_ready is 0 while reset is high.
- aluop encoding: add 00000, sub 00001, sll 00010, xor 00011, srl 00100, sra 00101, or 00110, and 00111, slt 01000, pass-op2 01001.
- out_sign: 1 for signed ops; 0 for SLTU/SLTIU/BLTU/BGEU; 1 for all others.
- OP (0110011): funct3/funct7[5] map directly to the encoding; op2=rs2_data; regwrite=1.
- OP-IMM (0010011): same mapping, no sub. op2 is the I-immediate. For shifts, op2 = {27'b0, insn[24:20]}; funct7[5] selects sra.
- LOAD (0000011): add, op2=I-imm, memread=1, regwrite=1.
- STORE (0100011): add, op2=S-imm, memwrite=1, out_rs2val=rs2_data.
- BRANCH (1100011): branch=1, op2=rs2_data, out_imm=B-imm. BEQ/BNE use sub (sign=1). BLT/BGE use slt with sign=1. BLTU/BGEU use slt with sign=0.
- LUI: pass-op2, op2=U-imm. AUIPC: add, data1=zero-extended in_pc, op2=U-imm. Both regwrite=1.
- Any other opcode is illegal: all controls 0, aluop 00000.
- A write with rd=0 forces regwrite=0.
- Handshake: transfer occurs when in_valid && in_ready. Slot loads on transfer. The slot empties (out_valid→0) when out_ready is high and there is no transfer.
- in_ready = !reset && !flush && bubble_cnt==0 && !hazard && (!out_valid || out_ready).
- While out_valid && !out_ready, all out_* are held stable.
- Load-use hazard: the slot holds a valid load with rd≠0, and in_insn reads that rd via rs1 or rs2 (x0 is never a hazard). Result:
  - in_ready=0.
  - When the load leaves the slot, bubble_cnt is loaded with LOAD_USE_BUBBLES−1, and out_valid=0 for LOAD_USE_BUBBLES cycles.
  - Then the dependent instruction is accepted.
- Flush has priority over everything. On the next edge: out_valid=0, bubble_cnt=0. Any input offered during the flush cycle is dropped (in_ready=0).
- Latency: 1 cycle from accept to out_valid. Sustained throughput: 1 instruction/cycle with no hazards.

Optional Feature:
- ILLEGAL_TRAP_EN
- Defined: an illegal instruction is accepted and issued with out_illegal=1 and all controls 0.
- Undefined: out_illegal is tied 0, and illegal words issue as a NOP (add, data1=0, op2=0, regwrite=0).

Test Plan:
- add x3,x1,x2 (0x002081B3), rs1_data=5, rs2_data=7 → next cycle: out_valid=1, aluop=00000, sign=1, data1=5, op2=7, rd=3, regwrite=1.
- srai x5,x6,3 (0x40335293), rs1_data=0x80000000 → aluop=00101, op2=3. sltu x1,x2,x3 (0x003130B3) → aluop=01000, sign=0.
- lw x4,0(x1) (0x0000A203) then add x5,x4,x2 (0x002202B3), LOAD_USE_BUBBLES=1 → in_ready=0 for one cycle, one out_valid=0 cycle, then the add issues.
- out_ready=0 for 3 cycles with out_valid=1 → all out_* stable and in_ready=0. out_ready=1 with in_valid=1 → back-to-back transfer.
- flush during a load-use stall → out_valid=0 next cycle, bubble cleared. An independent instruction is accepted the cycle after.
- 0xFFFFFFFF → with ILLEGAL_TRAP_EN: out_illegal=1, regwrite=0. Without it: NOP issued, out_illegal=0. Async reset mid-issue → out_valid=0 immediately.
